// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a 4-digit common-anode
// 7-segment module (active-low digits and segments, bit 7 = decimal point).
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   en                1 = display enabled, 0 = all digits off (scan continues)
//   brightness[3:0]   PWM level 0..15, sampled at each slot start
//   digit0..digit3    per-digit patterns, digit0 is rightmost
//   seg_out[11:0]     {dig_n[3:0], seg_n[7:0]}
//   scan_idx[1:0]     digit currently being scanned
//   frame_tick        one-cycle pulse at the end of every 4-slot frame
module seg7_scan_driver #(
    parameter int SCAN_DIV     = 12500,
    parameter int BLANK_CYCLES = 500
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [3:0]  brightness,
    input  logic [7:0]  digit0,
    input  logic [7:0]  digit1,
    input  logic [7:0]  digit2,
    input  logic [7:0]  digit3,
    output logic [11:0] seg_out,
    output logic [1:0]  scan_idx,
    output logic        frame_tick
);

    localparam int CW     = $clog2(SCAN_DIV);
    localparam int CW1    = CW + 1;
    localparam int PW     = CW + 5;
    localparam int ACTIVE = SCAN_DIV - BLANK_CYCLES;

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW:0]   BLANK_W  = CW1'(BLANK_CYCLES);
    localparam logic [PW-1:0] ACTIVE_W = PW'(ACTIVE);

    logic [CW-1:0] cnt;
    logic [CW-1:0] on_len_q;
    logic [CW-1:0] on_len_d;
    logic [1:0]    idx;
    logic [7:0]    pat_q;
    logic [7:0]    cur_digit;
    logic [3:0]    dig_q;
    logic [7:0]    seg_q;
    logic          cnt_last;
    logic          active;

    assign cnt_last = (cnt == CNT_LAST);

    // Lit window length: ACTIVE*(brightness+1)/16, product kept at full width
    // so large ACTIVE values are not truncated before the shift.
    assign on_len_d =
        CW'((ACTIVE_W * (PW'(brightness) + PW'(1))) >> 4);

    always_comb begin
        cur_digit = 8'hFF;
        unique case (idx)
            2'd0: cur_digit = digit0;
            2'd1: cur_digit = digit1;
            2'd2: cur_digit = digit2;
            2'd3: cur_digit = digit3;
        endcase
    end

    // Digits stay dark during the leading blank window to suppress ghosting.
    always_comb begin
        active = en
              && ({1'b0, cnt} >= BLANK_W)
              && ({1'b0, cnt} < BLANK_W + {1'b0, on_len_q});
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt        <= '0;
            idx        <= 2'd0;
            pat_q      <= 8'hFF;
            on_len_q   <= '0;
            dig_q      <= 4'hF;
            seg_q      <= 8'hFF;
            frame_tick <= 1'b0;
        end else begin
            if (cnt_last) begin
                cnt <= '0;
                idx <= idx + 2'd1;
            end else begin
                cnt <= cnt + CW'(1);
            end

            // Pattern and brightness captured once per slot: no tearing.
            if (cnt == '0) begin
                pat_q    <= cur_digit;
                on_len_q <= on_len_d;
            end

            dig_q      <= active ? ~(4'b0001 << idx) : 4'hF;
            seg_q      <= active ? pat_q : 8'hFF;
            frame_tick <= cnt_last && (idx == 2'd3);
        end
    end

    assign seg_out  = {dig_q, seg_q};
    assign scan_idx = idx;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: scoreboard bench for seg7_scan_driver with
// SCAN_DIV=16, BLANK_CYCLES=4 (12-cycle active window per slot).
module tb_seg7_scan_driver;

    localparam int SD = 16;
    localparam int BL = 4;
    localparam int AC = SD - BL;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b1;
    logic [3:0]  brightness = 4'd15;
    logic [7:0]  digit0 = 8'hC0;
    logic [7:0]  digit1 = 8'hF9;
    logic [7:0]  digit2 = 8'hA4;
    logic [7:0]  digit3 = 8'hB0;
    logic [11:0] seg_out;
    logic [1:0]  scan_idx;
    logic        frame_tick;

    typedef struct {
        logic [11:0] seg;
        logic [1:0]  idx;
        logic        tick;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    int checks = 0;
    int passes = 0;

    // Reference state: t = index of the next clock edge since reset release.
    int          t = 0;
    logic [7:0]  m_pat = 8'hFF;
    int          m_on = 0;

    seg7_scan_driver #(
        .SCAN_DIV(SD),
        .BLANK_CYCLES(BL)
    ) dut (
        .clk(clk),
        .reset(reset),
        .en(en),
        .brightness(brightness),
        .digit0(digit0),
        .digit1(digit1),
        .digit2(digit2),
        .digit3(digit3),
        .seg_out(seg_out),
        .scan_idx(scan_idx),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] pick(input int d);
        case (d)
            0: return digit0;
            1: return digit1;
            2: return digit2;
            default: return digit3;
        endcase
    endfunction

    // Predict the outputs after the coming edge, push them, advance a cycle.
    task automatic cycle();
        exp_t x;
        int   pos;
        int   d;
        logic lit;
        if (reset) begin
            x.seg  = 12'hFFF;
            x.idx  = 2'd0;
            x.tick = 1'b0;
            t      = 0;
            m_on   = 0;
            m_pat  = 8'hFF;
        end else begin
            pos = t % SD;
            d   = (t / SD) % 4;
            if (pos == 0) begin
                m_pat = pick(d);
                m_on  = (AC * (int'(brightness) + 1)) / 16;
            end
            lit    = en && (pos >= BL) && (pos < BL + m_on);
            x.seg  = lit ? {~(4'b0001 << d), m_pat} : 12'hFFF;
            x.idx  = 2'(((t + 1) / SD) % 4);
            x.tick = ((t % (4 * SD)) == (4 * SD - 1));
            t++;
        end
        sb.push_back(x);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx ||
                frame_tick !== e.tick)
                $display("FAIL reset: seg=%h idx=%0d tick=%b need %h %0d %b",
                         seg_out, scan_idx, frame_tick, e.seg, e.idx, e.tick);
            else passes++;
        end
        reset = 1'b0;
    endtask

    task automatic test_full_brightness();
        int ticks = 0;
        int last_tick = -1;
        int lit = 0;
        for (int i = 0; i < 2 * 4 * SD; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx ||
                frame_tick !== e.tick)
                $display("FAIL full[%0d]: seg=%h idx=%0d tick=%b need %h %0d %b",
                         i, seg_out, scan_idx, frame_tick,
                         e.seg, e.idx, e.tick);
            else passes++;
            if (seg_out !== 12'hFFF) lit++;
            if (frame_tick === 1'b1) begin
                if (last_tick >= 0) begin
                    checks++;
                    if (i - last_tick !== 4 * SD)
                        $display("FAIL tick_period: got %0d need %0d",
                                 i - last_tick, 4 * SD);
                    else passes++;
                end
                last_tick = i;
                ticks++;
            end
            if (i == 4) begin
                checks++;
                if (seg_out !== 12'hEC0)
                    $display("FAIL first_lit: seg=%h need ec0", seg_out);
                else passes++;
            end
        end
        checks++;
        if (ticks !== 2)
            $display("FAIL tick_count: got %0d need 2", ticks);
        else passes++;
        checks++;
        if (lit !== 8 * AC)
            $display("FAIL lit_full: got %0d need %0d", lit, 8 * AC);
        else passes++;
    endtask

    task automatic test_brightness_levels();
        int lit;
        brightness = 4'd7;
        while ((t % (4 * SD)) != 0) begin
            cycle();
            e = sb.pop_front();
        end
        lit = 0;
        for (int i = 0; i < 4 * SD; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx ||
                frame_tick !== e.tick)
                $display("FAIL bright7[%0d]: seg=%h need %h", i, seg_out, e.seg);
            else passes++;
            if (seg_out !== 12'hFFF) lit++;
        end
        checks++;
        if (lit !== 4 * 6)
            $display("FAIL lit_b7: got %0d need %0d", lit, 4 * 6);
        else passes++;
        brightness = 4'd0;
        while ((t % (4 * SD)) != 0) begin
            cycle();
            e = sb.pop_front();
        end
        lit = 0;
        for (int i = 0; i < 2 * 4 * SD; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx ||
                frame_tick !== e.tick)
                $display("FAIL bright0[%0d]: seg=%h need %h", i, seg_out, e.seg);
            else passes++;
            if (seg_out !== 12'hFFF) lit++;
        end
        checks++;
        if (lit !== 0)
            $display("FAIL lit_b0: got %0d need 0", lit);
        else passes++;
        brightness = 4'd15;
    endtask

    task automatic test_no_tearing();
        int old_n = 0;
        int new_n = 0;
        while ((t % (4 * SD)) != SD + 8) begin
            cycle();
            e = sb.pop_front();
        end
        digit1 = 8'h80;
        while ((t % (4 * SD)) != 2 * SD) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg)
                $display("FAIL tear_cur: seg=%h need %h", seg_out, e.seg);
            else passes++;
            if (seg_out === 12'hDF9) old_n++;
        end
        checks++;
        if (old_n !== 8)
            $display("FAIL tear_old: got %0d need 8", old_n);
        else passes++;
        for (int i = 0; i < 4 * SD; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx)
                $display("FAIL tear_next[%0d]: seg=%h need %h",
                         i, seg_out, e.seg);
            else passes++;
            if (seg_out === 12'hD80) new_n++;
        end
        checks++;
        if (new_n !== AC)
            $display("FAIL tear_new: got %0d need %0d", new_n, AC);
        else passes++;
    endtask

    task automatic test_en_gate();
        int dark = 0;
        while ((t % SD) != 6) begin
            cycle();
            e = sb.pop_front();
        end
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== 12'hFFF || e.seg !== 12'hFFF ||
                scan_idx !== e.idx || frame_tick !== e.tick)
                $display("FAIL en_off[%0d]: seg=%h idx=%0d need fff %0d",
                         i, seg_out, scan_idx, e.idx);
            else passes++;
            if (seg_out === 12'hFFF) dark++;
        end
        en = 1'b1;
        for (int i = 0; i < 4 * SD; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx ||
                frame_tick !== e.tick)
                $display("FAIL en_on[%0d]: seg=%h idx=%0d tick=%b need %h %0d %b",
                         i, seg_out, scan_idx, frame_tick,
                         e.seg, e.idx, e.tick);
            else passes++;
        end
        checks++;
        if (dark !== 3)
            $display("FAIL en_dark: got %0d need 3", dark);
        else passes++;
    endtask

    task automatic test_reset_mid_slot();
        while ((t % (4 * SD)) != 2 * SD + 8) begin
            cycle();
            e = sb.pop_front();
        end
        reset = 1'b1;
        cycle();
        e = sb.pop_front();
        checks++;
        if (seg_out !== 12'hFFF || scan_idx !== 2'd0 || frame_tick !== 1'b0)
            $display("FAIL rst_mid: seg=%h idx=%0d tick=%b need fff 0 0",
                     seg_out, scan_idx, frame_tick);
        else passes++;
        reset = 1'b0;
        for (int i = 0; i < 2 * SD; i++) begin
            cycle();
            e = sb.pop_front();
            checks++;
            if (seg_out !== e.seg || scan_idx !== e.idx ||
                frame_tick !== e.tick)
                $display("FAIL rst_restart[%0d]: seg=%h idx=%0d need %h %0d",
                         i, seg_out, scan_idx, e.seg, e.idx);
            else passes++;
            if (i == 3 || i == 4) begin
                checks++;
                if (seg_out !== ((i == 3) ? 12'hFFF : 12'hEC0))
                    $display("FAIL rst_blank[%0d]: seg=%h", i, seg_out);
                else passes++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_brightness();
        test_brightness_levels();
        test_no_tearing();
        test_en_gate();
        test_reset_mid_slot();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
